// File: rtl/reg_pipe_elastic.sv
`default_nettype none
// ============================================================================
// Module   : reg_pipe_elastic
// Brief    : DEPTH-stage elastic register pipeline with per-stage valid bits,
//            valid/ready handshake on both sides and bubble collapse.
// Revision : 1.0 - initial release
// ============================================================================
module reg_pipe_elastic #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               CNTW  = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  input  logic [WIDTH-1:0]  D_IN,
  input  logic              D_VALID,
  output logic              D_READY,
  output logic [WIDTH-1:0]  Q_OUT,
  output logic              Q_VALID,
  input  logic              Q_READY,
  output logic [CNTW-1:0]   COUNT
);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CNTW-1:0]  r_count;

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_open;
  logic             w_enq;
  logic             w_deq;

  // Readiness ripples from the output stage back toward the input stage.
  always_comb begin
    w_adv  = '0;
    w_open = '0;
    w_adv[DEPTH-1]  = r_v[DEPTH-1] & Q_READY;
    w_open[DEPTH-1] = ~r_v[DEPTH-1] | w_adv[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_adv[i]  = r_v[i] & w_open[i+1];
      w_open[i] = ~r_v[i] | w_adv[i];
    end
  end

  assign w_enq   = D_VALID & w_open[0];
  assign w_deq   = w_adv[DEPTH-1];
  assign D_READY = w_open[0];
  assign Q_OUT   = r_d[DEPTH-1];
  assign Q_VALID = r_v[DEPTH-1];
  assign COUNT   = r_count;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_v     <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= INIT;
      end
    end else if (CLR) begin
      // Flush drops validity only; data registers keep their stale contents.
      r_v     <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_d[0] <= D_IN;
        r_v[0] <= 1'b1;
      end else if (w_adv[0]) begin
        r_v[0] <= 1'b0;
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (w_adv[i]) begin
          r_d[i+1] <= r_d[i];
          r_v[i+1] <= 1'b1;
        end else if (w_adv[i+1]) begin
          r_v[i+1] <= 1'b0;
        end
      end
      r_count <= r_count + CNTW'(w_enq) - CNTW'(w_deq);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_pipe_elastic.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_pipe_elastic
// Brief    : Directed scoreboard bench for reg_pipe_elastic (DEPTH=3, WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_pipe_elastic;

  localparam int         c_WIDTH = 8;
  localparam int         c_DEPTH = 3;
  localparam logic [7:0] c_INIT  = 8'h5A;
  localparam int         c_CNTW  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       d_valid = 1'b0;
  logic       d_ready;
  logic [7:0] q_out;
  logic       q_valid;
  logic       q_ready = 1'b0;
  logic [4:0] count;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb [$];

  reg_pipe_elastic #(
    .WIDTH (c_WIDTH),
    .DEPTH (c_DEPTH),
    .INIT  (c_INIT),
    .CNTW  (c_CNTW)
  ) u_dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .CLR     (clr),
    .D_IN    (d_in),
    .D_VALID (d_valid),
    .D_READY (d_ready),
    .Q_OUT   (q_out),
    .Q_VALID (q_valid),
    .Q_READY (q_ready),
    .COUNT   (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every accepted output word is matched against the expected-order queue.
  always @(negedge clk) begin
    if (rst_n && !clr && q_valid && q_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_output: got %0h expected none", q_out);
      end else begin
        logic [7:0] exp_w;
        exp_w = sb.pop_front();
        if (q_out !== exp_w) begin
          n_errors++;
          $display("FAIL sb_data: got %0h expected %0h", q_out, exp_w);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nwin;
    int nout;

    // Reset then idle
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    settle();
    chk("rst_q_out",   q_out,   8'h5A);
    chk("rst_q_valid", q_valid, 1'b0);
    chk("rst_count",   count,   5'd0);
    chk("rst_d_ready", d_ready, 1'b1);

    // Single word, latency of DEPTH cycles, one-cycle output pulse
    q_ready = 1'b1;
    d_in = 8'h11; d_valid = 1'b1; sb.push_back(8'h11);
    step();
    d_valid = 1'b0;
    chk("lat_c1_q_valid", q_valid, 1'b0);
    step();
    chk("lat_c2_q_valid", q_valid, 1'b0);
    step();
    chk("lat_c3_q_valid", q_valid, 1'b1);
    chk("lat_c3_q_out",   q_out,   8'h11);
    step();
    chk("lat_c4_q_valid", q_valid, 1'b0);
    chk("lat_c4_count",   count,   5'd0);

    // Back-to-back stream 01..0A
    nwin = 0; nout = 0;
    for (int c = 0; c < 14; c++) begin
      if (q_valid) begin
        if (c >= 3 && c <= 12) nwin++;
        else nout++;
      end
      if (c < 10) begin
        d_in = 8'(c + 1); d_valid = 1'b1; sb.push_back(8'(c + 1));
        settle();
        chk("stream_d_ready", d_ready, 1'b1);
      end else begin
        d_valid = 1'b0;
      end
      step();
    end
    chk("stream_valid_cycles", nwin, 10);
    chk("stream_stray_valid",  nout, 0);
    chk("stream_count",        count, 5'd0);

    // Back-pressure: 4th word held until one word leaves
    q_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      d_in = 8'(8'h21 + c); d_valid = 1'b1; sb.push_back(8'(8'h21 + c));
      step();
    end
    d_in = 8'h24; d_valid = 1'b1;
    settle();
    chk("bp_full_count",   count,   5'd3);
    chk("bp_full_d_ready", d_ready, 1'b0);
    step();
    chk("bp_hold_count", count, 5'd3);
    chk("bp_hold_q_out", q_out, 8'h21);
    q_ready = 1'b1; sb.push_back(8'h24);
    settle();
    chk("bp_shift_d_ready", d_ready, 1'b1);
    step();
    d_valid = 1'b0; q_ready = 1'b0;
    chk("bp_after_count", count, 5'd3);
    chk("bp_after_q_out", q_out, 8'h22);
    q_ready = 1'b1;
    step(); step(); step();
    chk("bp_drain_count", count, 5'd0);

    // Bubble collapse while the output is stalled
    q_ready = 1'b0;
    d_in = 8'hA1; d_valid = 1'b1; sb.push_back(8'hA1);
    step();
    d_valid = 1'b0;
    step(); step();
    d_in = 8'hB2; d_valid = 1'b1; sb.push_back(8'hB2);
    step();
    d_valid = 1'b0;
    step(); step(); step();
    settle();
    chk("bub_count",   count,   5'd2);
    chk("bub_q_out",   q_out,   8'hA1);
    chk("bub_d_ready", d_ready, 1'b1);
    q_ready = 1'b1;
    step();
    chk("bub_adj_q_valid", q_valid, 1'b1);
    chk("bub_adj_q_out",   q_out,   8'hB2);
    step();
    chk("bub_drain_q_valid", q_valid, 1'b0);
    chk("bub_drain_count",   count,   5'd0);

    // CLR on a full pipe with a concurrent enqueue and dequeue request
    q_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      d_in = 8'(8'h31 + c); d_valid = 1'b1;
      step();
    end
    d_in = 8'h3F; d_valid = 1'b1; clr = 1'b1; q_ready = 1'b1;
    settle();
    chk("clr_d_ready", d_ready, 1'b1);
    step();
    clr = 1'b0; d_valid = 1'b0; q_ready = 1'b0;
    chk("clr_q_valid", q_valid, 1'b0);
    chk("clr_count",   count,   5'd0);
    chk("clr_q_out",   q_out,   8'h31);
    q_ready = 1'b1;
    step(); step(); step(); step();
    chk("clr_drop_count",   count,   5'd0);
    chk("clr_drop_q_valid", q_valid, 1'b0);

    // Reset in the middle of a stream
    for (int c = 0; c < 3; c++) begin
      d_in = 8'(8'h41 + c); d_valid = 1'b1; sb.push_back(8'(8'h41 + c));
      step();
    end
    d_valid = 1'b0; rst_n = 1'b0;
    step();
    sb.delete();
    chk("mrst_q_out",   q_out,   8'h5A);
    chk("mrst_q_valid", q_valid, 1'b0);
    chk("mrst_count",   count,   5'd0);
    rst_n = 1'b1;
    nout = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (q_valid) nout++;
    end
    chk("mrst_no_output", nout, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
